psum_acc_ctrl: RTL

//  Read-modify-write initiator for the synchronous psum memory (pmem). Accepts a stream of
//  (address, partial sum) beats from the PE array, reads the stored psum, adds, writes it back.
//  On command, drains a range of accumulated psums as an output stream.

---
 rtl/psum_acc_pkg.sv | 32 +++
 rtl/psum_sat_add.sv | 27 ++
 rtl/psum_acc_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/psum_acc_pkg.sv
// Shared definitions for psum accumulation blocks: controller state encoding and a
// signed saturating add usable for any psum width up to 32 bits.
package psum_acc_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFlush = 2'd1,
    StDrain = 2'd2
  } acc_state_e;

  localparam int unsigned SatMaxWidth = 32;

  // Operands are sign-extended to 32 bits by the caller; the result is clipped to the
  // signed range of 'width' bits and returned sign-extended.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned width);
    logic signed [32:0] sum;
    logic signed [32:0] max_v;
    logic signed [32:0] min_v;
    sum   = {a[31], a} + {b[31], b};
    max_v = (33'sd1 <<< (width - 1)) - 33'sd1;
    min_v = -(33'sd1 <<< (width - 1));
    if (sum > max_v) begin
      return max_v[31:0];
    end else if (sum < min_v) begin
      return min_v[31:0];
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/psum_sat_add.sv
// Combinational signed saturating adder of width DATA_WIDTH (at most 32).
module psum_sat_add
  import psum_acc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] sum_o
);

  logic signed [31:0] a_ext;
  logic signed [31:0] b_ext;
  logic signed [31:0] res;
  logic               unused_res;

  always_comb begin
    a_ext = 32'(signed'(a_i));
    b_ext = 32'(signed'(b_i));
    res   = sat_add(a_ext, b_ext, DATA_WIDTH);
  end

  assign sum_o      = res[DATA_WIDTH-1:0];
  // Upper bits only carry the sign extension of the clipped result.
  assign unused_res = ^res;

endmodule

// File: rtl/psum_acc_ctrl.sv
// Read-modify-write accumulator front-end for the psum memory, with a drain mode that
// streams addresses 0..len-1 out through a valid/ready register.
module psum_acc_ctrl
  import psum_acc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_psum_valid,
  output logic                  o_psum_ready,
  input  logic [ADDR_WIDTH-1:0] i_psum_addr,
  input  logic [DATA_WIDTH-1:0] i_psum_data,
  input  logic                  i_psum_first,
  input  logic                  i_drain_start,
  input  logic [ADDR_WIDTH-1:0] i_drain_len,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_out_last,
  output logic                  o_busy,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
  output logic                  o_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] o_mem_wr_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wr_data
);

  acc_state_e state_q, state_d;

  logic                  s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_first_q, s1_first_d;

  logic                  byp_valid_q, byp_valid_d;
  logic [ADDR_WIDTH-1:0] byp_addr_q, byp_addr_d;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;

  logic [ADDR_WIDTH-1:0] drain_addr_q, drain_addr_d;
  logic [ADDR_WIDTH-1:0] drain_len_q, drain_len_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic                  inflight_last_q, inflight_last_d;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;

  logic                  accept;
  logic                  drain_go;
  logic                  byp_hit;
  logic                  out_hs;
  logic                  rd_issue;
  logic [DATA_WIDTH-1:0] old_val;
  logic [DATA_WIDTH-1:0] add_res;
  logic [DATA_WIDTH-1:0] wr_sum;

  assign o_psum_ready = (state_q == StIdle) & ~i_drain_start;
  assign accept       = i_psum_valid & o_psum_ready;
  assign drain_go     = (state_q == StIdle) & i_drain_start & (i_drain_len != '0);

  // Bypass covers the read issued while the same address was being written.
  assign byp_hit = byp_valid_q & (byp_addr_q == s1_addr_q);
  assign old_val = byp_hit ? byp_data_q : i_mem_rd_data;

  psum_sat_add #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sat_add (
    .a_i  (old_val),
    .b_i  (s1_data_q),
    .sum_o(add_res)
  );

  assign wr_sum        = s1_first_q ? s1_data_q : add_res;
  assign o_mem_wr_en   = s1_valid_q;
  assign o_mem_wr_addr = s1_addr_q;
  assign o_mem_wr_data = wr_sum;

  assign out_hs   = out_valid_q & i_out_ready;
  assign rd_issue = (state_q == StDrain) & (drain_addr_q != drain_len_q) & ~rd_inflight_q &
                    (~out_valid_q | out_hs);

  // Accept and drain reads live in different states, so they never collide.
  assign o_mem_rd_en   = accept | rd_issue;
  assign o_mem_rd_addr = rd_issue ? drain_addr_q : i_psum_addr;

  assign o_out_valid = out_valid_q;
  assign o_out_data  = out_data_q;
  assign o_out_last  = out_last_q;
  assign o_busy      = (state_q != StIdle) | s1_valid_q;

  always_comb begin
    state_d         = state_q;
    s1_valid_d      = accept;
    s1_addr_d       = s1_addr_q;
    s1_data_d       = s1_data_q;
    s1_first_d      = s1_first_q;
    byp_valid_d     = s1_valid_q;
    byp_addr_d      = byp_addr_q;
    byp_data_d      = byp_data_q;
    drain_addr_d    = drain_addr_q;
    drain_len_d     = drain_len_q;
    rd_inflight_d   = rd_issue;
    inflight_last_d = inflight_last_q;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_last_d      = out_last_q;

    if (accept) begin
      s1_addr_d  = i_psum_addr;
      s1_data_d  = i_psum_data;
      s1_first_d = i_psum_first;
    end

    if (s1_valid_q) begin
      byp_addr_d = s1_addr_q;
      byp_data_d = wr_sum;
    end

    if (drain_go) begin
      drain_addr_d = '0;
      drain_len_d  = i_drain_len;
    end

    if (rd_issue) begin
      drain_addr_d    = drain_addr_q + 1'b1;
      inflight_last_d = (drain_addr_q == drain_len_q - 1'b1);
    end

    // A read is only issued when the output register will be free on return.
    if (rd_inflight_q) begin
      out_valid_d = 1'b1;
      out_data_d  = i_mem_rd_data;
      out_last_d  = inflight_last_q;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (drain_go) begin
          state_d = s1_valid_q ? StFlush : StDrain;
        end
      end
      StFlush: begin
        if (!s1_valid_q) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_hs && out_last_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= StIdle;
      s1_valid_q      <= 1'b0;
      s1_addr_q       <= '0;
      s1_data_q       <= '0;
      s1_first_q      <= 1'b0;
      byp_valid_q     <= 1'b0;
      byp_addr_q      <= '0;
      byp_data_q      <= '0;
      drain_addr_q    <= '0;
      drain_len_q     <= '0;
      rd_inflight_q   <= 1'b0;
      inflight_last_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_last_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      s1_valid_q      <= s1_valid_d;
      s1_addr_q       <= s1_addr_d;
      s1_data_q       <= s1_data_d;
      s1_first_q      <= s1_first_d;
      byp_valid_q     <= byp_valid_d;
      byp_addr_q      <= byp_addr_d;
      byp_data_q      <= byp_data_d;
      drain_addr_q    <= drain_addr_d;
      drain_len_q     <= drain_len_d;
      rd_inflight_q   <= rd_inflight_d;
      inflight_last_q <= inflight_last_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_last_q      <= out_last_d;
    end
  end

endmodule
